// File: rtl/mux_nto1_stream_if.sv
// Handshake and bus bundle for mux_nto1_stream.
// Optional i_last/q_last members exist when MUX_NTO1_LAST_LOCK_EN is defined.
interface mux_nto1_stream_if #(
    parameter int WIDTH  = 19,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic                    mode;
    logic [SEL_W-1:0]        S;
    logic [NUM_IN*WIDTH-1:0] i_data;
    logic [NUM_IN-1:0]       i_valid;
    logic [NUM_IN-1:0]       i_ready;
    logic [WIDTH-1:0]        Q;
    logic                    q_valid;
    logic                    q_ready;
    logic [SEL_W-1:0]        q_src;
`ifdef MUX_NTO1_LAST_LOCK_EN
    logic [NUM_IN-1:0]       i_last;
    logic                    q_last;
`endif

    modport master (
`ifdef MUX_NTO1_LAST_LOCK_EN
        output i_last,
        input  q_last,
`endif
        output mode, S, i_data, i_valid, q_ready,
        input  i_ready, Q, q_valid, q_src
    );

    modport slave (
`ifdef MUX_NTO1_LAST_LOCK_EN
        input  i_last,
        output q_last,
`endif
        input  mode, S, i_data, i_valid, q_ready,
        output i_ready, Q, q_valid, q_src
    );
endinterface

// File: rtl/mux_nto1_stream.sv
// Registered N-to-1 stream mux with external select or round-robin grant.
// Define MUX_NTO1_LAST_LOCK_EN to lock round-robin grants until a last beat.
module mux_nto1_stream #(
    parameter int WIDTH  = 19,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input logic               clk,
    input logic               rst,
    mux_nto1_stream_if.slave bus
);
    logic             load;
    logic             gnt_ok;
    logic [SEL_W-1:0] gnt;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_next;
    logic [WIDTH-1:0] sel_data;
`ifdef MUX_NTO1_LAST_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_ch;
    logic             sel_last;
`endif

    assign load    = !bus.q_valid || bus.q_ready;
    assign rr_next = (gnt == SEL_W'(NUM_IN - 1)) ? '0 : gnt + SEL_W'(1);

    // Pick the granted channel: external select, lock holder, or round-robin.
    always_comb begin
        int idx;
        gnt_ok = 1'b0;
        gnt    = '0;
        idx    = 0;
        if (!bus.mode) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (bus.S == SEL_W'(k) && bus.i_valid[k]) begin
                    gnt_ok = 1'b1;
                    gnt    = SEL_W'(k);
                end
            end
        end
`ifdef MUX_NTO1_LAST_LOCK_EN
        else if (locked) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (lock_ch == SEL_W'(k) && bus.i_valid[k]) begin
                    gnt_ok = 1'b1;
                    gnt    = SEL_W'(k);
                end
            end
        end
`endif
        else begin
            // Walk offsets far-to-near so the nearest valid channel wins.
            for (int off = NUM_IN - 1; off >= 0; off--) begin
                idx = int'(rr_ptr) + off;
                if (idx >= NUM_IN) idx = idx - NUM_IN;
                for (int k = 0; k < NUM_IN; k++) begin
                    if (k == idx && bus.i_valid[k]) begin
                        gnt_ok = 1'b1;
                        gnt    = SEL_W'(k);
                    end
                end
            end
        end
    end

    // Route the granted channel's word (and last flag) to the register input.
    always_comb begin
        sel_data = '0;
`ifdef MUX_NTO1_LAST_LOCK_EN
        sel_last = 1'b0;
`endif
        for (int k = 0; k < NUM_IN; k++) begin
            if (gnt == SEL_W'(k)) begin
                sel_data = bus.i_data[k*WIDTH +: WIDTH];
`ifdef MUX_NTO1_LAST_LOCK_EN
                sel_last = bus.i_last[k];
`endif
            end
        end
    end

    // Accept only the granted channel, and only when the register can load.
    always_comb begin
        bus.i_ready = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            bus.i_ready[k] = !rst && load && gnt_ok && (gnt == SEL_W'(k));
        end
    end

    // Output register, round-robin pointer and packet lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Q       <= '0;
            bus.q_valid <= 1'b0;
            bus.q_src   <= '0;
            rr_ptr      <= '0;
`ifdef MUX_NTO1_LAST_LOCK_EN
            bus.q_last  <= 1'b0;
            locked      <= 1'b0;
            lock_ch     <= '0;
`endif
        end else begin
            if (load && gnt_ok) begin
                bus.Q       <= sel_data;
                bus.q_src   <= gnt;
                bus.q_valid <= 1'b1;
`ifdef MUX_NTO1_LAST_LOCK_EN
                bus.q_last  <= sel_last;
                if (bus.mode) begin
                    if (sel_last) begin
                        locked <= 1'b0;
                        rr_ptr <= rr_next;
                    end else begin
                        locked  <= 1'b1;
                        lock_ch <= gnt;
                    end
                end
`else
                if (bus.mode) rr_ptr <= rr_next;
`endif
            end else if (load) begin
                bus.q_valid <= 1'b0;
            end
`ifdef MUX_NTO1_LAST_LOCK_EN
            if (!bus.mode) locked <= 1'b0;
`endif
        end
    end
endmodule
